instr_route_seq: RTL and testbench
==================================

INSTR_ROUTE_SEQ -- requirements
Module: instr_route_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of instruction bytes and routed data.
REQ-002 Parameter DEMUX_SELECT_BITS, default 2, width of route select.
REQ-003 Parameter ADDR_WIDTH, default 8, program-memory address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  begin execution at address 0 from IDLE or HALT.
REQ-007 pmem_rd_en  output  1  program-memory read strobe.
REQ-008 pmem_addr  output  ADDR_WIDTH  program-memory read address.
REQ-009 pmem_rdata  input  DATA_WIDTH  read data, valid exactly 1 cycle after pmem_rd_en.
REQ-010 select  output  DEMUX_SELECT_BITS  route to the downstream demux: 00 register file, 01 memory, 10 immediate.
REQ-011 data_to_demux  output  DATA_WIDTH  operand byte presented to the demux.
REQ-012 out_valid  output  1  select/data_to_demux valid.
REQ-013 out_ready  input  1  downstream accepts the transfer.
REQ-014 halted  output  1  sequencer is in HALT.
REQ-015 issue_count  output  8  number of completed transfers since the last reset or start; wraps 255->0.

Function
REQ-016 Opcode byte format: bits[7:6] class; class 00/01/10 is a routed instruction followed by one operand byte; class 11 is control: bit0=1 HALT, bit0=0 NOP (no operand).
REQ-017 FSM states: IDLE, REQ_OP, LAT_OP, REQ_ARG, LAT_ARG, ISSUE, HALT.
REQ-018 IDLE/HALT: on start, pc<=0, issue_count<=0, go to REQ_OP; otherwise hold state.
REQ-019 REQ_OP: pmem_rd_en=1, pmem_addr=pc; pc<=pc+1; go to LAT_OP.
REQ-020 LAT_OP: latch pmem_rdata as opcode; class 11 with bit0=1 -> HALT; class 11 with bit0=0 -> REQ_OP; otherwise -> REQ_ARG.
REQ-021 REQ_ARG: pmem_rd_en=1, pmem_addr=pc; pc<=pc+1; go to LAT_ARG.
REQ-022 LAT_ARG: latch pmem_rdata as operand; go to ISSUE.
REQ-023 ISSUE: out_valid=1, select=opcode[7:6], data_to_demux=operand; hold all three stable while out_ready=0.
REQ-024 ISSUE with out_ready=1: transfer completes that cycle; issue_count increments; next state REQ_OP.
REQ-025 Latency: from the REQ_OP cycle to the first out_valid cycle is exactly 4 cycles.
REQ-026 Outside ISSUE: out_valid=0; select and data_to_demux hold their last issued values.
REQ-027 pmem_rd_en=0 in all states except REQ_OP/REQ_ARG; pmem_addr=pc in every state.
REQ-028 pc wraps from 2^ADDR_WIDTH-1 to 0 with no flag.
REQ-029 start is ignored in all states except IDLE and HALT.
REQ-030 halted=1 only in HALT.

Reset
REQ-031 rst=1 at a clock edge forces IDLE, pc=0, opcode=0, operand=0, issue_count=0, and all outputs 0 on the following cycle, from any state.
REQ-032 rst asserted during ISSUE drops out_valid with no completed transfer and no issue_count increment.
REQ-033 rst has priority over start in the same cycle.

Structure
REQ-034 The shared package holds the state enum, the class encodings (ROUTE_RF=00, ROUTE_MEM=01, ROUTE_IMM=10, ROUTE_CTRL=11), and the HALT bit index.
REQ-035 The block is a single module with no sub-modules; the ISSUE-stage output register is inline.

Verification
REQ-036 Program {0x00,0x5A,0xC1}, out_ready=1, start -> one transfer, select=00, data=0x5A, 4 cycles after REQ_OP; then halted=1, issue_count=1.
REQ-037 Program {0x40,0x11,0x80,0x22,0xC1} -> transfers (01,0x11) then (10,0x22); HALT at pc=5.
REQ-038 out_ready=0 for 3 ISSUE cycles, then 1 -> select/data stable for all 4 cycles; exactly one count increment.
REQ-039 Program {0xC0,0xC0,0xC1} -> no out_valid pulses; HALT at pc=3.
REQ-040 rst pulse during ISSUE -> out_valid=0 the next cycle, IDLE, issue_count=0; start afterwards refetches from address 0.
REQ-041 ADDR_WIDTH=2, program {0xC0,0xC0,0xC0,0x00} followed by wrap -> pc sequence 0,1,2,3,0; the operand is fetched from address 0.

Source files
------------

// File: rtl/instr_route_seq_pkg.sv
// Shared types and encodings for the instruction route sequencer.
package instr_route_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_OP  = 3'd1,
    S_LAT_OP  = 3'd2,
    S_REQ_ARG = 3'd3,
    S_LAT_ARG = 3'd4,
    S_ISSUE   = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [1:0] ROUTE_RF   = 2'b00;
  localparam logic [1:0] ROUTE_MEM  = 2'b01;
  localparam logic [1:0] ROUTE_IMM  = 2'b10;
  localparam logic [1:0] ROUTE_CTRL = 2'b11;

  // Opcode field positions: class in the top two bits, halt flag in bit 0.
  localparam int unsigned CLASS_MSB = 7;
  localparam int unsigned CLASS_LSB = 6;
  localparam int unsigned HALT_BIT  = 0;

endpackage

// File: rtl/instr_route_seq.sv
// Fetches opcode/operand pairs from program memory and hands each operand
// to a downstream demux with a valid/ready handshake.
module instr_route_seq
  import instr_route_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DEMUX_SELECT_BITS = 2,
  parameter int unsigned ADDR_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         pmem_rd_en,
  output logic [ADDR_WIDTH-1:0]        pmem_addr,
  input  logic [DATA_WIDTH-1:0]        pmem_rdata,
  output logic [DEMUX_SELECT_BITS-1:0] select,
  output logic [DATA_WIDTH-1:0]        data_to_demux,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         halted,
  output logic [7:0]                   issue_count
);

  state_t                         state, state_nx;
  logic [ADDR_WIDTH-1:0]          pc_nx;
  logic [1:0]                     op_class, op_class_nx;
  logic [DEMUX_SELECT_BITS-1:0]   select_nx;
  logic [DATA_WIDTH-1:0]          data_nx;
  logic [7:0]                     count_nx;

  // The program counter is the read address in every state.
  logic [ADDR_WIDTH-1:0] pc;
  assign pmem_addr = pc;

  // Next-state and next-value decode; only the class bits of the opcode are kept.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    op_class_nx = op_class;
    select_nx   = select;
    data_nx     = data_to_demux;
    count_nx    = issue_count;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nx    = '0;
          count_nx = '0;
          state_nx = S_REQ_OP;
        end
      end
      S_REQ_OP: begin
        pc_nx    = pc + ADDR_WIDTH'(1);
        state_nx = S_LAT_OP;
      end
      S_LAT_OP: begin
        op_class_nx = pmem_rdata[CLASS_MSB:CLASS_LSB];
        if (pmem_rdata[CLASS_MSB:CLASS_LSB] == ROUTE_CTRL) begin
          state_nx = pmem_rdata[HALT_BIT] ? S_HALT : S_REQ_OP;
        end else begin
          state_nx = S_REQ_ARG;
        end
      end
      S_REQ_ARG: begin
        pc_nx    = pc + ADDR_WIDTH'(1);
        state_nx = S_LAT_ARG;
      end
      S_LAT_ARG: begin
        // The output register doubles as the operand latch.
        data_nx   = pmem_rdata;
        select_nx = DEMUX_SELECT_BITS'(op_class);
        state_nx  = S_ISSUE;
      end
      S_ISSUE: begin
        if (out_ready) begin
          count_nx = issue_count + 8'd1;
          state_nx = S_REQ_OP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and datapath registers; strobes are decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= '0;
      op_class      <= '0;
      select        <= '0;
      data_to_demux <= '0;
      issue_count   <= '0;
      pmem_rd_en    <= 1'b0;
      out_valid     <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      op_class      <= op_class_nx;
      select        <= select_nx;
      data_to_demux <= data_nx;
      issue_count   <= count_nx;
      pmem_rd_en    <= (state_nx == S_REQ_OP) || (state_nx == S_REQ_ARG);
      out_valid     <= (state_nx == S_ISSUE);
      halted        <= (state_nx == S_HALT);
    end
  end

endmodule

// File: tb/tb_instr_route_seq.sv
// Scoreboard bench for instr_route_seq: stimulus pushes expected transfers,
// a negedge monitor pops and compares them as the DUT completes handshakes.
module tb_instr_route_seq;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, out_ready;
  logic       pmem_rd_en, out_valid, halted;
  logic [7:0] pmem_addr, pmem_rdata, data_to_demux, issue_count;
  logic [1:0] select;

  logic       rst_w, start_w;
  logic       rd_en_w, valid_w, halted_w;
  logic [1:0] addr_w, sel_w;
  logic [7:0] rdata_w, data_w, count_w;

  int tests = 0;
  int fails = 0;
  int valid_cycles = 0;
  xfer_t exp_q[$];
  logic [1:0] addr_log[$];
  logic [7:0] mem [256];
  logic [7:0] mem_w [4];

  instr_route_seq #(.DATA_WIDTH(8), .DEMUX_SELECT_BITS(2), .ADDR_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .pmem_rd_en(pmem_rd_en), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
    .select(select), .data_to_demux(data_to_demux),
    .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .issue_count(issue_count)
  );

  instr_route_seq #(.DATA_WIDTH(8), .DEMUX_SELECT_BITS(2), .ADDR_WIDTH(2)) u_wrap (
    .clk(clk), .rst(rst_w), .start(start_w),
    .pmem_rd_en(rd_en_w), .pmem_addr(addr_w), .pmem_rdata(rdata_w),
    .select(sel_w), .data_to_demux(data_w),
    .out_valid(valid_w), .out_ready(1'b1),
    .halted(halted_w), .issue_count(count_w)
  );

  // Program memories with one-cycle read latency.
  always @(posedge clk) if (pmem_rd_en) pmem_rdata <= mem[pmem_addr];
  always @(posedge clk) if (rd_en_w) rdata_w <= mem_w[addr_w];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: hold-stability while stalled, scoreboard compare on each completed transfer.
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [1:0] prev_sel = 2'b00;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cycles <= valid_cycles + 1;
      if (prev_valid && !prev_ready) begin
        check("hold_select", 32'(select), 32'(prev_sel));
        check("hold_data", 32'(data_to_demux), 32'(prev_data));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got sel=%0d data=0x%0h expected no transfer", select, data_to_demux);
        end else begin
          check("xfer_select", 32'(select), 32'(exp_q[0].sel));
          check("xfer_data", 32'(data_to_demux), 32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
    end
    prev_valid <= !rst && out_valid;
    prev_ready <= out_ready;
    prev_sel   <= select;
    prev_data  <= data_to_demux;
  end

  // Read-address log of the narrow-address instance.
  always @(negedge clk) if (!rst_w && rd_en_w) addr_log.push_back(addr_w);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 8'hC1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(halted), 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    int n;
    logic [1:0] exp_pc [5];
    exp_pc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    rst_w = 1'b1; start_w = 1'b0;
    fill_halt();
    mem_w[0] = 8'hC0; mem_w[1] = 8'hC0; mem_w[2] = 8'hC0; mem_w[3] = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    rst_w = 1'b0;

    // Reset state.
    check("rst_rd_en", 32'(pmem_rd_en), 0);
    check("rst_addr", 32'(pmem_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_count", 32'(issue_count), 0);
    check("rst_sel_data", 32'({select, data_to_demux}), 0);

    // Single RF transfer, latency from REQ_OP to out_valid.
    mem[0] = 8'h00; mem[1] = 8'h5A; mem[2] = 8'hC1;
    exp_q.push_back('{sel: 2'b00, data: 8'h5A});
    tick();
    pulse_start();
    check("first_rd_en", 32'(pmem_rd_en), 1);
    check("first_addr", 32'(pmem_addr), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("latency_c%0d", i), 32'(out_valid), (i == 4) ? 1 : 0);
    end
    wait_halt("halt_t1");
    check("count_t1", 32'(issue_count), 1);
    check("pc_t1", 32'(pmem_addr), 3);

    // MEM then IMM transfers; restart from HALT.
    fill_halt();
    mem[0] = 8'h40; mem[1] = 8'h11; mem[2] = 8'h80; mem[3] = 8'h22; mem[4] = 8'hC1;
    exp_q.push_back('{sel: 2'b01, data: 8'h11});
    exp_q.push_back('{sel: 2'b10, data: 8'h22});
    pulse_start();
    wait_halt("halt_t2");
    check("count_t2", 32'(issue_count), 2);
    check("pc_t2", 32'(pmem_addr), 5);

    // NOPs only: no transfers.
    fill_halt();
    mem[0] = 8'hC0; mem[1] = 8'hC0; mem[2] = 8'hC1;
    vc0 = valid_cycles;
    pulse_start();
    wait_halt("halt_t3");
    check("pc_t3", 32'(pmem_addr), 3);
    check("count_t3", 32'(issue_count), 0);
    check("no_valid_t3", 32'(valid_cycles - vc0), 0);

    // Back-pressure: three stalled ISSUE cycles, then accepted.
    fill_halt();
    mem[0] = 8'h80; mem[1] = 8'h33; mem[2] = 8'hC1;
    exp_q.push_back('{sel: 2'b10, data: 8'h33});
    out_ready = 1'b0;
    tick();
    vc0 = valid_cycles;
    pulse_start();
    wait_valid("valid_t4");
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    wait_halt("halt_t4");
    check("valid_cycles_t4", 32'(valid_cycles - vc0), 4);
    check("count_t4", 32'(issue_count), 1);

    // Reset during ISSUE, then reset-over-start priority, then refetch.
    fill_halt();
    mem[0] = 8'h00; mem[1] = 8'h77; mem[2] = 8'hC1;
    out_ready = 1'b0;
    pulse_start();
    wait_valid("valid_t5");
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid_after_rst", 32'(out_valid), 0);
    check("t5_halted_after_rst", 32'(halted), 0);
    check("t5_count_after_rst", 32'(issue_count), 0);
    check("t5_sel_data_after_rst", 32'({select, data_to_demux}), 0);
    start = 1'b1;
    rst = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    check("t5_rst_over_start", 32'(pmem_rd_en), 0);
    tick();
    check("t5_still_idle", 32'(pmem_rd_en), 0);
    exp_q.push_back('{sel: 2'b00, data: 8'h77});
    pulse_start();
    check("t5_refetch_rd_en", 32'(pmem_rd_en), 1);
    check("t5_refetch_addr", 32'(pmem_addr), 0);
    wait_halt("halt_t5");
    check("count_t5", 32'(issue_count), 1);

    // Two-bit address: pc wraps and the operand comes from address 0.
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    n = 0;
    while (!valid_w && n < 100) begin
      tick();
      n++;
    end
    check("wrap_valid", 32'(valid_w), 1);
    check("wrap_reads", 32'(addr_log.size()), 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      check($sformatf("wrap_pc%0d", i), 32'(addr_log[i]), 32'(exp_pc[i]));
    check("wrap_select", 32'(sel_w), 0);
    check("wrap_data", 32'(data_w), 32'h00C0);
    tick();
    check("wrap_count", 32'(count_w), 1);
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    check("wrap_rst", 32'({halted_w, valid_w, count_w}), 0);

    tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
